// File: rtl/wide_ff_pkg.sv
// Shared types and default parameters for the wide FF skid slice.
package wide_ff_pkg;

  // Slice occupancy: EMPTY (nothing held), FULL (main only), SKID (main + skid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b10
  } state_t;

  localparam int          DEF_WIDTH     = 4;
  localparam logic [3:0]  DEF_RESET_VAL = 4'b0110;
  localparam int          DEF_CNT_W     = 4;

endpackage

// File: rtl/wide_ff_reg.sv
// WIDTH-bit data register with async clear, sync clear and clock enable.
// Both clears load RESET_VAL so the power-up, clr and flush values agree.
module wide_ff_reg #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = 4'b0110
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // Data storage: async clr, then sync flush, then enabled load; otherwise hold.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_r <= RESET_VAL;
    end else if (flush) begin
      q_r <= RESET_VAL;
    end else if (en) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/wide_ff_skid_slice.sv
// Two-entry valid/ready skid slice. All handshake outputs come straight from
// flops, so there is no combinational path from out_ready to in_ready.
module wide_ff_skid_slice
  import wide_ff_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = DEF_RESET_VAL,
  parameter int               CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] cnt_r;

  logic             accept_s;
  logic             take_s;
  logic             main_en_s;
  logic             skid_en_s;
  logic             main_from_skid_s;
  logic [WIDTH-1:0] main_d_s;
  logic [WIDTH-1:0] main_q_s;
  logic [WIDTH-1:0] skid_q_s;

  assign accept_s = in_valid & in_ready_r;
  assign take_s   = out_valid_r & out_ready;

  // Next-state and data-register load decisions; flush overrides the state only,
  // the data registers apply flush themselves.
  always_comb begin
    state_nxt_s      = state_r;
    main_en_s        = 1'b0;
    skid_en_s        = 1'b0;
    main_from_skid_s = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
          main_en_s   = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s && take_s) begin
          state_nxt_s = ST_FULL;
          main_en_s   = 1'b1;
        end else if (accept_s) begin
          state_nxt_s = ST_SKID;
          skid_en_s   = 1'b1;
        end else if (take_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      ST_SKID: begin
        if (take_s) begin
          state_nxt_s      = ST_FULL;
          main_en_s        = 1'b1;
          main_from_skid_s = 1'b1;
        end else begin
          state_nxt_s = ST_SKID;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // Main register refills from the skid entry when draining SKID, else from input.
  always_comb begin
    if (main_from_skid_s) begin
      main_d_s = skid_q_s;
    end else begin
      main_d_s = in_data;
    end
  end

  // State and registered handshake flags, derived from the next state.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_SKID);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // Completed output handshakes; wraps naturally and ignores flush.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (take_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  wide_ff_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .en    (main_en_s),
    .d     (main_d_s),
    .q     (main_q_s)
  );

  wide_ff_reg #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk   (clk),
    .clr   (clr),
    .flush (flush),
    .en    (skid_en_s),
    .d     (in_data),
    .q     (skid_q_s)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_q_s;
  assign xfer_cnt  = cnt_r;

endmodule

// File: tb/tb_wide_ff_skid_slice.sv
// Self-checking bench for wide_ff_skid_slice: directed scenarios plus random
// valid/ready traffic, all compared against a queue-based reference model.
module tb_wide_ff_skid_slice;

  localparam logic [3:0] RST_VAL = 4'b0110;

  logic       clk;
  logic       clr;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [3:0] xfer_cnt;

  int n_cmp;
  int n_bad;

  // Reference model: a FIFO of at most two words plus the last value shown.
  logic [3:0] mq[$];
  logic [3:0] m_last;
  logic       m_in_ready;
  logic [3:0] m_cnt;

  wide_ff_skid_slice #(.WIDTH(4), .RESET_VAL(4'b0110), .CNT_W(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_last     = RST_VAL;
    m_in_ready = 1'b0;
    m_cnt      = 4'd0;
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_step();
    logic acc;
    logic tk;
    acc = in_valid & m_in_ready;
    tk  = (mq.size() > 0) & out_ready;
    if (tk) m_cnt = m_cnt + 4'd1;
    if (flush) begin
      mq.delete();
      m_last = RST_VAL;
    end else begin
      if (tk) m_last = mq.pop_front();
      if (acc) mq.push_back(in_data);
    end
    m_in_ready = (mq.size() < 2);
  endtask

  task automatic check_outputs();
    chk("in_ready", 32'(in_ready), 32'(m_in_ready));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_data", 32'(out_data), 32'((mq.size() > 0) ? mq[0] : m_last));
    chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  endtask

  // Inputs are driven 1 time unit after a posedge, outputs checked 1 unit after the next.
  task automatic cycle(input logic iv, input logic [3:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  // Pulse clr asynchronously and check the cleared outputs while it is held.
  task automatic do_clr();
    clr = 1'b1;
    #2;
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_out_data", 32'(out_data), 32'(RST_VAL));
    chk("clr_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    chk("post_clr_in_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    clr       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    model_reset();
    #1;
    do_clr();
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    chk("first_in_ready", 32'(in_ready), 32'd1);

    // Test 1: clr in the middle of traffic.
    cycle(1'b1, 4'h7, 1'b0, 1'b0);
    cycle(1'b1, 4'h8, 1'b0, 1'b0);
    do_clr();
    cycle(1'b0, 4'd0, 1'b0, 1'b0);

    // Test 2: back-to-back stream 1..9 with out_ready high.
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, 4'(i), 1'b1, 1'b0);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_data", 32'(out_data), 32'(i));
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("stream_cnt", 32'(xfer_cnt), 32'd9);

    // Test 3: stall, fill both entries, hold off a third word, then drain in order.
    do_clr();
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'hA, 1'b0, 1'b0);
    cycle(1'b1, 4'hB, 1'b0, 1'b0);
    chk("skid_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 4'hC, 1'b0, 1'b0);
    chk("held_data", 32'(out_data), 32'hA);
    cycle(1'b1, 4'hC, 1'b1, 1'b0);
    chk("drain_b", 32'(out_data), 32'hB);
    cycle(1'b1, 4'hC, 1'b1, 1'b0);
    chk("drain_c", 32'(out_data), 32'hC);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("drain_cnt", 32'(xfer_cnt), 32'd3);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Test 4: flush from SKID with an input offered.
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 4'h5, 1'b0, 1'b0);
    cycle(1'b1, 4'h9, 1'b0, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_out_data", 32'(out_data), 32'(RST_VAL));
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b0, 4'd0, 1'b1, 1'b0);
    chk("flush_dropped", 32'(out_valid), 32'd0);

    // Test 5: counter wrap over 18 takes.
    do_clr();
    cycle(1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 4'd1, 1'b1, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      cycle(1'b1, 4'(i + 1), 1'b1, 1'b0);
      if (i == 15) chk("cnt_15", 32'(xfer_cnt), 32'd15);
      if (i == 16) chk("cnt_16", 32'(xfer_cnt), 32'd0);
      if (i == 18) chk("cnt_18", 32'(xfer_cnt), 32'd2);
    end

    // Test 6: random valid/ready with occasional flush.
    do_clr();
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
